// File: rtl/tx_frame_scheduler_if.sv
// Queue-side and engine-side handshake bundle for tx_frame_scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface tx_frame_scheduler_if #(
    parameter int NQ    = 4,
    parameter int QW    = 2,
    parameter int LEN_W = 10
);
    logic [NQ-1:0]       q_req;
    logic [NQ*LEN_W-1:0] q_len_qw;
    logic [NQ-1:0]       q_grant;
    logic [NQ-1:0]       q_done;
    logic                eng_start;
    logic [QW-1:0]       eng_qsel;
    logic [LEN_W-1:0]    eng_len_qw;
    logic                eng_ack;
    logic                eng_done;
    logic                eng_abort;

    modport master (
        input  q_req, q_len_qw, eng_ack, eng_done,
        output q_grant, q_done, eng_start, eng_qsel, eng_len_qw, eng_abort
    );

    modport slave (
        output q_req, q_len_qw, eng_ack, eng_done,
        input  q_grant, q_done, eng_start, eng_qsel, eng_len_qw, eng_abort
    );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Frame-granularity round-robin arbiter sharing one tx MAC engine among NQ queues,
// with a completion watchdog. Define TX_SCHED_IFG_EN to insert IFG_CYCLES idle cycles between frames.
//
// state | meaning
// IDLE  | arbitrate among eligible queues when enabled
// ISSUE | eng_start held with latched qsel/len until eng_ack
// WAIT  | frame in flight; watchdog counting down to abort
// GAP   | inter-frame idle cycles (TX_SCHED_IFG_EN builds only)
module tx_frame_scheduler #(
    parameter int NQ         = 4,
    parameter int QW         = 2,
    parameter int LEN_W      = 10,
    parameter int TIMEOUT    = 4096,
    parameter int IFG_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    tx_frame_scheduler_if.master bus,
    output logic                 timeout_err,
    output logic [31:0]          frames_sent
);

    if (NQ < 2 || NQ > 8 || QW != $clog2(NQ) || TIMEOUT < 1 || TIMEOUT > 65535 ||
        IFG_CYCLES < 1 || IFG_CYCLES > 255) begin : g_param_err
        $error("tx_frame_scheduler: illegal parameter combination");
    end

    localparam logic [15:0]    WD_LOAD = 16'(TIMEOUT - 1);
    localparam logic [NQ-1:0]  ONE_HOT = NQ'(1);

`ifdef TX_SCHED_IFG_EN
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
    logic [7:0] gap_left;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
`endif

    state_t            state;
    logic [QW-1:0]     last_sel;
    logic [15:0]       wd_left;

    logic [LEN_W-1:0]  len_arr [NQ];
    logic [NQ-1:0]     elig;
    logic              found;
    logic [QW-1:0]     pick;
    logic [QW-1:0]     cand;

    // Rotating priority scan starting just after the last served queue.
    always_comb begin
        found = 1'b0;
        pick  = last_sel;
        cand  = '0;
        for (int i = 0; i < NQ; i++) begin
            len_arr[i] = bus.q_len_qw[i*LEN_W +: LEN_W];
            elig[i]    = bus.q_req[i] && (len_arr[i] != '0);
        end
        for (int k = 1; k <= NQ; k++) begin
            cand = QW'((int'(last_sel) + k) % NQ);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            last_sel       <= QW'(NQ - 1);
            wd_left        <= '0;
            bus.q_grant    <= '0;
            bus.q_done     <= '0;
            bus.eng_start  <= 1'b0;
            bus.eng_qsel   <= '0;
            bus.eng_len_qw <= '0;
            bus.eng_abort  <= 1'b0;
            timeout_err    <= 1'b0;
            frames_sent    <= '0;
`ifdef TX_SCHED_IFG_EN
            gap_left       <= '0;
`endif
        end else begin
            bus.q_done    <= '0;
            bus.eng_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable && found) begin
                        bus.q_grant    <= ONE_HOT << pick;
                        bus.eng_qsel   <= pick;
                        bus.eng_len_qw <= len_arr[pick];
                        bus.eng_start  <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.eng_ack) begin
                        bus.eng_start <= 1'b0;
                        wd_left       <= WD_LOAD;
                        state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion takes precedence over a simultaneous watchdog expiry.
                    if (bus.eng_done) begin
                        bus.q_done  <= bus.q_grant;
                        bus.q_grant <= '0;
                        frames_sent <= frames_sent + 32'd1;
                        last_sel    <= bus.eng_qsel;
`ifdef TX_SCHED_IFG_EN
                        gap_left    <= 8'(IFG_CYCLES - 1);
                        state       <= S_GAP;
`else
                        state       <= S_IDLE;
`endif
                    end else if (wd_left <= 16'd1) begin
                        bus.eng_abort <= 1'b1;
                        timeout_err   <= 1'b1;
                        bus.q_grant   <= '0;
                        last_sel      <= bus.eng_qsel;
`ifdef TX_SCHED_IFG_EN
                        gap_left      <= 8'(IFG_CYCLES - 1);
                        state         <= S_GAP;
`else
                        state         <= S_IDLE;
`endif
                    end else begin
                        wd_left <= wd_left - 16'd1;
                    end
                end
`ifdef TX_SCHED_IFG_EN
                S_GAP: begin
                    if (gap_left == '0) state <= S_IDLE;
                    else                gap_left <= gap_left - 8'd1;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler: arbitration order, latching, watchdog,
// enable gating, zero-length filtering, inter-frame spacing and mid-frame reset.
module tb_tx_frame_scheduler;
    localparam int NQ    = 4;
    localparam int QW    = 2;
    localparam int LEN_W = 10;
`ifdef TX_SCHED_IFG_EN
    localparam int EXP_GAP = 4;
`else
    localparam int EXP_GAP = 2;
`endif

    logic        clk;
    logic        reset;
    logic        enable;
    logic        timeout_err;
    logic [31:0] frames_sent;
    int          n_cmp;
    int          n_mis;

    tx_frame_scheduler_if #(.NQ(NQ), .QW(QW), .LEN_W(LEN_W)) bus ();

    tx_frame_scheduler #(
        .NQ(NQ), .QW(QW), .LEN_W(LEN_W), .TIMEOUT(16), .IFG_CYCLES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bus         (bus.master),
        .timeout_err (timeout_err),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int q, input int len);
        bus.q_len_qw[q*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.q_req    = '0;
        bus.q_len_qw = '0;
        bus.eng_ack  = 1'b0;
        bus.eng_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_start();
        int lat = 0;
        while (!bus.eng_start && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.eng_start) chk("start_timeout", 32'd0, 32'd1);
    endtask

    // One complete grant: check the command, ack it, hold, then pulse done.
    task automatic serve(input int q, input int len, input int hold, input bit clr_req);
        wait_start();
        chk("qsel", 32'(bus.eng_qsel), 32'(q));
        chk("len", 32'(bus.eng_len_qw), 32'(len));
        chk("grant", 32'(bus.q_grant), 32'(1 << q));
        bus.eng_ack = 1'b1;
        if (clr_req) bus.q_req = '0;
        @(negedge clk);
        bus.eng_ack = 1'b0;
        chk("start_drop", 32'(bus.eng_start), 32'd0);
        repeat (hold - 1) @(negedge clk);
        bus.eng_done = 1'b1;
        @(negedge clk);
        bus.eng_done = 1'b0;
        chk("q_done", 32'(bus.q_done), 32'(1 << q));
        chk("grant_rel", 32'(bus.q_grant), 32'd0);
        @(negedge clk);
        chk("q_done_pulse", 32'(bus.q_done), 32'd0);
    endtask

    initial begin
        int bad;
        int lat;
        n_cmp  = 0;
        n_mis  = 0;
        enable = 1'b1;
        bus.q_req    = '0;
        bus.q_len_qw = '0;
        bus.eng_ack  = 1'b0;
        bus.eng_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        do_reset();

        chk("rst_grant", 32'(bus.q_grant), 32'd0);
        chk("rst_start", 32'(bus.eng_start), 32'd0);
        chk("rst_qsel", 32'(bus.eng_qsel), 32'd0);
        chk("rst_len", 32'(bus.eng_len_qw), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_frames", frames_sent, 32'd0);

        // Single queue, start one cycle after request
        bus.q_req = 4'b0001;
        set_len(0, 8);
        @(negedge clk);
        chk("t1_start", 32'(bus.eng_start), 32'd1);
        serve(0, 8, 4, 1'b1);
        chk("t1_frames", frames_sent, 32'd1);

        // All four requesting from fresh reset: order 0,1,2,3,0
        do_reset();
        bus.q_req = 4'b1111;
        for (int i = 0; i < NQ; i++) set_len(i, 5);
        serve(0, 5, 10, 1'b0);
        serve(1, 5, 10, 1'b0);
        serve(2, 5, 10, 1'b0);
        serve(3, 5, 10, 1'b0);
        serve(0, 5, 10, 1'b1);
        chk("t2_frames", frames_sent, 32'd5);

        // Zero-length queue 2 skipped; enable=0 lets frame finish but blocks regrant
        bus.q_len_qw = '0;
        set_len(3, 3);
        bus.q_req = 4'b1100;
        wait_start();
        chk("t5_qsel", 32'(bus.eng_qsel), 32'd3);
        bus.eng_ack = 1'b1;
        @(negedge clk);
        bus.eng_ack = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        bus.eng_done = 1'b1;
        @(negedge clk);
        bus.eng_done = 1'b0;
        chk("t5_done", 32'(bus.q_done), 32'b1000);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.eng_start || bus.q_grant[2]) bad++;
        end
        chk("t5_blocked", 32'(bad), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("t5_regrant", 32'(bus.eng_start), 32'd1);
        serve(3, 3, 4, 1'b1);
        chk("t5_frames", frames_sent, 32'd7);

        // Queue 2; request and length yanked during WAIT
        bus.q_req = 4'b0100;
        set_len(2, 5);
        wait_start();
        chk("t3_qsel", 32'(bus.eng_qsel), 32'd2);
        bus.eng_ack = 1'b1;
        @(negedge clk);
        bus.eng_ack = 1'b0;
        bus.q_req = '0;
        set_len(2, 0);
        repeat (4) @(negedge clk);
        chk("t3_len_held", 32'(bus.eng_len_qw), 32'd5);
        bus.eng_done = 1'b1;
        @(negedge clk);
        bus.eng_done = 1'b0;
        chk("t3_done", 32'(bus.q_done), 32'b0100);
        chk("t3_frames", frames_sent, 32'd8);

        // Watchdog: abort 16 cycles after ack, then queue 0 is granted
        bus.q_req = 4'b1000;
        set_len(3, 7);
        wait_start();
        chk("t4_qsel", 32'(bus.eng_qsel), 32'd3);
        bus.eng_ack = 1'b1;
        bus.q_req = 4'b0001;
        set_len(0, 4);
        set_len(3, 0);
        bad = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.eng_ack = 1'b0;
            if (bus.eng_abort || bus.q_done != '0 || bus.eng_start) bad++;
        end
        chk("t4_early", 32'(bad), 32'd0);
        @(negedge clk);
        chk("t4_abort", 32'(bus.eng_abort), 32'd1);
        chk("t4_terr", 32'(timeout_err), 32'd1);
        chk("t4_grant", 32'(bus.q_grant), 32'd0);
        chk("t4_nodone", 32'(bus.q_done), 32'd0);
        @(negedge clk);
        chk("t4_abort_pulse", 32'(bus.eng_abort), 32'd0);
        chk("t4_next", 32'(bus.eng_start), 32'd1);
        serve(0, 4, 3, 1'b0);
        chk("t4_frames", frames_sent, 32'd9);

        // Spacing from eng_done to next eng_start with continuous requester
        wait_start();
        bus.eng_ack = 1'b1;
        @(negedge clk);
        bus.eng_ack = 1'b0;
        repeat (2) @(negedge clk);
        bus.eng_done = 1'b1;
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.eng_done = 1'b0;
            lat++;
            if (bus.eng_start) break;
        end
        chk("t6_gap", 32'(lat), 32'(EXP_GAP));
        chk("t6_terr_sticky", 32'(timeout_err), 32'd1);

        // Reset mid-frame drops the grant silently
        bus.eng_ack = 1'b1;
        @(negedge clk);
        bus.eng_ack = 1'b0;
        chk("t7_granted", 32'(bus.q_grant), 32'b0001);
        reset = 1'b1;
        @(negedge clk);
        chk("t7_grant", 32'(bus.q_grant), 32'd0);
        chk("t7_done", 32'(bus.q_done), 32'd0);
        chk("t7_abort", 32'(bus.eng_abort), 32'd0);
        chk("t7_terr", 32'(timeout_err), 32'd0);
        chk("t7_frames", frames_sent, 32'd0);
        reset = 1'b0;
        bus.q_req = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit reached");
    end
endmodule
